pipeline_stall_ctrl: RTL and testbench

//  Parametrised pipeline hazard/stall controller for the N-stage MIPS datapath. Drives per-latch

---
 rtl/data_path_muxs_pkg.sv | 18 +
 rtl/pipeline_stall_ctrl_if.sv | 44 ++++
 rtl/stall_sat_counter.sv | 23 ++
 rtl/pipeline_stall_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_path_muxs_pkg.sv
// Shared datapath mux selections and stall-controller types.
//   pc_mux_input_selection : PC register source (sequential or branch target)
//   stall_state_t          : pipeline_stall_ctrl FSM states
package data_path_muxs_pkg;

   typedef enum logic {
      PC_PLUS4  = 1'b0,
      PC_BRANCH = 1'b1
   } pc_mux_input_selection;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } stall_state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle of the stall-controller signals, with a dut modport (controller side)
// and a tb modport (datapath / bench side).
// Signal meanings match pipeline_stall_ctrl port for port.
interface pipeline_stall_ctrl_if
   import data_path_muxs_pkg::*;
#(
   parameter int STAGES = 5,
   parameter int REGW   = 5,
   parameter int CNTW   = 32
) (
   input logic CLK
);
   logic                  nRST;
   logic                  ihit;
   logic                  dhit;
   logic                  dmemREN;
   logic                  dmemWEN;
   logic                  dREN_ID_EX;
   logic [REGW-1:0]       Rt_ID_EX;
   logic [REGW-1:0]       Rs_IF_ID;
   logic [REGW-1:0]       Rt_IF_ID;
   logic                  rt_used_IF_ID;
   logic                  branch_taken;
   logic                  halt_IF_ID;
   logic [STAGES-2:0]     enable;
   logic [STAGES-2:0]     flush;
   logic                  enable_pc;
   pc_mux_input_selection PCSrc;
   logic                  halted;
   logic [CNTW-1:0]       stall_cycles;
   stall_state_t          state_dbg;

   modport dut (
      input  CLK, nRST, ihit, dhit, dmemREN, dmemWEN, dREN_ID_EX, Rt_ID_EX,
             Rs_IF_ID, Rt_IF_ID, rt_used_IF_ID, branch_taken, halt_IF_ID,
      output enable, flush, enable_pc, PCSrc, halted, stall_cycles, state_dbg
   );

   modport tb (
      input  CLK, enable, flush, enable_pc, PCSrc, halted, stall_cycles, state_dbg,
      output nRST, ihit, dhit, dmemREN, dmemWEN, dREN_ID_EX, Rt_ID_EX,
             Rs_IF_ID, Rt_IF_ID, rt_used_IF_ID, branch_taken, halt_IF_ID
   );
endinterface

// File: rtl/stall_sat_counter.sv
// W-bit up counter that stops at all ones instead of wrapping.
//   CLK   : clock, rising edge
//   nRST  : asynchronous reset, active low (clears count)
//   inc   : count this cycle
//   count : current value
module stall_sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard / stall controller for the N-stage MIPS pipeline.
// Produces per-latch load enables and bubble (flush) requests, the PC load
// enable and PC mux select, from the memory handshakes, load-use detection,
// a resolved branch and the halt opcode. Latch i sits between stage i and i+1.
//
// Memory handshake: a request (dmemREN/dmemWEN) with dhit low is still
// outstanding; the whole pipeline freezes until dhit is seen. ihit low means
// no instruction is available this cycle and a bubble enters IF_ID.
//
// Ports:
//   CLK, nRST            clock (rising) / async active-low reset
//   ihit, dhit           I-fetch / D-access complete this cycle
//   dmemREN, dmemWEN     MEM-stage read / write request
//   dREN_ID_EX, Rt_ID_EX load in ID_EX and its destination register
//   Rs_IF_ID, Rt_IF_ID   sources of the IF_ID instruction; rt_used_IF_ID: rt read
//   branch_taken         redirect resolved in latch BR_LATCH
//   halt_IF_ID           halt opcode in IF_ID
//   enable, flush        per-latch load enable / bubble insert (needs enable)
//   enable_pc, PCSrc     PC load enable and source select
//   halted               sticky, pipeline drained after halt
//   stall_cycles         saturating count of cycles with PC held while not halted
//   state_dbg            current FSM state
// Parameter limits: STAGES >= 3, 1 <= BR_LATCH <= STAGES-2, LU_CYC >= 1.
module pipeline_stall_ctrl
   import data_path_muxs_pkg::*;
#(
   parameter int STAGES   = 5,
   parameter int REGW     = 5,
   parameter int BR_LATCH = 2,
   parameter int LU_CYC   = 1,
   parameter int CNTW     = 32
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  ihit,
   input  logic                  dhit,
   input  logic                  dmemREN,
   input  logic                  dmemWEN,
   input  logic                  dREN_ID_EX,
   input  logic [REGW-1:0]       Rt_ID_EX,
   input  logic [REGW-1:0]       Rs_IF_ID,
   input  logic [REGW-1:0]       Rt_IF_ID,
   input  logic                  rt_used_IF_ID,
   input  logic                  branch_taken,
   input  logic                  halt_IF_ID,
   output logic [STAGES-2:0]     enable,
   output logic [STAGES-2:0]     flush,
   output logic                  enable_pc,
   output pc_mux_input_selection PCSrc,
   output logic                  halted,
   output logic [CNTW-1:0]       stall_cycles,
   output stall_state_t          state_dbg
);

   localparam int NL  = STAGES - 1;
   localparam int LUW = (LU_CYC > 1) ? $clog2(LU_CYC) : 1;
   localparam int DW  = (STAGES > 3) ? $clog2(STAGES - 1) : 1;

   localparam logic [LUW-1:0] LU_INIT    = LUW'(LU_CYC - 1);
   localparam logic [DW-1:0]  DRAIN_INIT = DW'(STAGES - 2);
   // Latches 0..BR_LATCH hold instructions younger than the branch.
   localparam logic [NL-1:0]  BR_MASK    = NL'((1 << (BR_LATCH + 1)) - 1);

   stall_state_t   state, state_nx;
   logic [LUW-1:0] lu_cnt, lu_cnt_nx;
   logic [DW-1:0]  drain_cnt, drain_cnt_nx;
   logic           dwait;
   logic           lu;
   logic           stall_inc;

   assign dwait = (dmemREN || dmemWEN) && !dhit;

   // $0 is never a real dependency.
   assign lu = dREN_ID_EX && (Rt_ID_EX != '0) &&
               ((Rt_ID_EX == Rs_IF_ID) || (rt_used_IF_ID && (Rt_ID_EX == Rt_IF_ID)));

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= RUN;
         lu_cnt    <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nx;
         lu_cnt    <= lu_cnt_nx;
         drain_cnt <= drain_cnt_nx;
      end
   end

   // Next state. lu_cnt / drain_cnt count the cycles still to spend in
   // LU_STALL / DRAIN including the current one, so the last cycle is cnt==1.
   always_comb begin
      state_nx     = state;
      lu_cnt_nx    = lu_cnt;
      drain_cnt_nx = drain_cnt;
      if ((state != HALTED) && !dwait) begin
         case (state)
            RUN: begin
               if (branch_taken) begin
                  lu_cnt_nx = '0;
               end else if (lu) begin
                  // One bubble is issued right now; only extra ones need LU_STALL.
                  if (LU_CYC > 1) begin
                     state_nx  = LU_STALL;
                     lu_cnt_nx = LU_INIT;
                  end
               end else if (halt_IF_ID && ihit) begin
                  state_nx     = DRAIN;
                  drain_cnt_nx = DRAIN_INIT;
               end
            end
            LU_STALL: begin
               if (branch_taken || (lu_cnt <= LUW'(1))) begin
                  state_nx  = RUN;
                  lu_cnt_nx = '0;
               end else begin
                  lu_cnt_nx = lu_cnt - LUW'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt <= DW'(1)) begin
                  state_nx     = HALTED;
                  drain_cnt_nx = '0;
               end else begin
                  drain_cnt_nx = drain_cnt - DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode, highest priority first. The halt instruction itself
   // advances normally; fetch stops from the first DRAIN cycle on.
   always_comb begin
      enable    = '0;
      flush     = '0;
      enable_pc = 1'b0;
      PCSrc     = PC_PLUS4;
      halted    = 1'b0;
      if (!nRST) begin
         flush = '1;
      end else if (state == HALTED) begin
         halted = 1'b1;
      end else if (dwait) begin
         // freeze: everything held
      end else if (state == DRAIN) begin
         // branch_taken cannot come from an instruction older than halt here
         enable   = '1;
         flush[0] = 1'b1;
      end else if (branch_taken) begin
         // the in-flight fetch is discarded, so ihit is not needed
         enable    = '1;
         flush     = BR_MASK;
         PCSrc     = PC_BRANCH;
         enable_pc = 1'b1;
      end else if ((state == LU_STALL) || lu) begin
         enable    = '1;
         enable[0] = 1'b0;
         flush[1]  = 1'b1;
      end else if (!ihit) begin
         enable   = '1;
         flush[0] = 1'b1;
      end else begin
         enable    = '1;
         enable_pc = 1'b1;
      end
   end

   assign stall_inc = nRST && !enable_pc && !halted;
   assign state_dbg = state;

   stall_sat_counter #(
      .W(CNTW)
   ) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl (STAGES=5, BR_LATCH=2, LU_CYC=2, CNTW=4).
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge. Single-cycle table from reset, hand-written multi-cycle
// sequences, then random traffic against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;
   import data_path_muxs_pkg::*;

   localparam int STAGES   = 5;
   localparam int REGW     = 5;
   localparam int BR_LATCH = 2;
   localparam int LU_CYC   = 2;
   localparam int CNTW     = 4;
   localparam int NL       = STAGES - 1;
   localparam int OW       = 2 * NL + 3 + CNTW;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   // ---------------- clock / reset / DUT ----------------
   logic                  CLK = 1'b0;
   logic                  nRST = 1'b0;
   logic                  ihit, dhit, dmemREN, dmemWEN, dREN_ID_EX;
   logic [REGW-1:0]       Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
   logic                  rt_used_IF_ID, branch_taken, halt_IF_ID;
   logic [NL-1:0]         enable, flush;
   logic                  enable_pc;
   pc_mux_input_selection PCSrc;
   logic                  halted;
   logic [CNTW-1:0]       stall_cycles;
   stall_state_t          state_dbg;
   logic                  src_bit;

   always #5 CLK = ~CLK;
   assign src_bit = PCSrc;

   pipeline_stall_ctrl #(
      .STAGES(STAGES), .REGW(REGW), .BR_LATCH(BR_LATCH), .LU_CYC(LU_CYC), .CNTW(CNTW)
   ) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN),
      .dmemWEN(dmemWEN), .dREN_ID_EX(dREN_ID_EX), .Rt_ID_EX(Rt_ID_EX),
      .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .rt_used_IF_ID(rt_used_IF_ID),
      .branch_taken(branch_taken), .halt_IF_ID(halt_IF_ID), .enable(enable),
      .flush(flush), .enable_pc(enable_pc), .PCSrc(PCSrc), .halted(halted),
      .stall_cycles(stall_cycles), .state_dbg(state_dbg)
   );

   // ---------------- stimulus types ----------------
   typedef struct packed {
      logic            ihit, dhit, ren, wen, dren;
      logic [REGW-1:0] rt_ex, rs_id, rt_id;
      logic            rt_used, br, halt;
   } in_t;

   typedef struct {
      in_t           in;
      logic [NL-1:0] en;
      logic [NL-1:0] fl;
      logic          pc;
      logic          src;
      string         name;
   } vec_t;

   vec_t tbl[$];

   function automatic in_t mk_in(input logic ihit, dhit, ren, wen, dren,
                                 input int rt_ex, rs_id, rt_id,
                                 input logic rt_used, br, halt);
      in_t r;
      r.ihit = ihit; r.dhit = dhit; r.ren = ren; r.wen = wen; r.dren = dren;
      r.rt_ex = REGW'(rt_ex); r.rs_id = REGW'(rs_id); r.rt_id = REGW'(rt_id);
      r.rt_used = rt_used; r.br = br; r.halt = halt;
      return r;
   endfunction

   task automatic add_vec(input in_t in, input logic [NL-1:0] en, fl,
                          input logic pc, src, input string name);
      vec_t v;
      v.in = in; v.en = en; v.fl = fl; v.pc = pc; v.src = src; v.name = name;
      tbl.push_back(v);
   endtask

   // ---------------- scoreboard ----------------
   logic [OW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic check_out(input logic [NL-1:0] en, fl, input logic pc, src, hlt,
                            input int st, input string name);
      logic [OW-1:0] act, expv;
      exp_q.push_back({en, fl, pc, src, hlt, CNTW'(st)});
      act  = {enable, flush, enable_pc, src_bit, halted, stall_cycles};
      expv = exp_q.pop_front();
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s @%0t (state=%0d): got en=%b fl=%b pc=%b src=%b halted=%b stall=%0d, want en=%b fl=%b pc=%b src=%b halted=%b stall=%0d",
                  name, $time, state_dbg, enable, flush, enable_pc, src_bit, halted,
                  stall_cycles, en, fl, pc, src, hlt, st);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic apply(input in_t v);
      ihit = v.ihit; dhit = v.dhit; dmemREN = v.ren; dmemWEN = v.wen;
      dREN_ID_EX = v.dren; Rt_ID_EX = v.rt_ex; Rs_IF_ID = v.rs_id;
      Rt_IF_ID = v.rt_id; rt_used_IF_ID = v.rt_used; branch_taken = v.br;
      halt_IF_ID = v.halt;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step(input in_t v, input logic [NL-1:0] en, fl, input logic pc,
                       src, hlt, input int st, input string name);
      apply(v);
      @(negedge CLK);
      check_out(en, fl, pc, src, hlt, st, name);
      tick();
   endtask

   in_t idle_v, lu_v, dw_v, halt_v, noihit_v, br_lu_v, br_v;

   task automatic do_reset();
      nRST = 1'b0;
      apply(idle_v);
      @(negedge CLK);
      check_out('0, '1, L, L, L, 0, "reset");
      tick();
      nRST = 1'b1;
   endtask

   // ---------------- behavioural reference model ----------------
   bit m_halted;
   int m_lu_left;
   int m_drain_left;
   int m_stall;

   task automatic model_reset();
      m_halted = 0; m_lu_left = 0; m_drain_left = 0; m_stall = 0;
   endtask

   // Expected outputs for this cycle from the current model state, then advance.
   task automatic model_eval(input in_t v, output logic [NL-1:0] en, fl,
                             output logic pc, src, hlt, output int st);
      bit dwait, lu;
      int all_ones;
      all_ones = (1 << NL) - 1;
      dwait = (v.ren || v.wen) && !v.dhit;
      lu = v.dren && (v.rt_ex != 0) &&
           ((v.rt_ex == v.rs_id) || (v.rt_used && (v.rt_ex == v.rt_id)));
      en = '0; fl = '0; pc = 0; src = 0; hlt = 0;
      st = m_stall;
      if (m_halted) begin
         hlt = 1;
      end else if (dwait) begin
         // frozen
      end else if (m_drain_left > 0) begin
         en = NL'(all_ones); fl = NL'(1);
         m_drain_left--;
         if (m_drain_left == 0) m_halted = 1;
      end else if (v.br) begin
         en = NL'(all_ones); fl = NL'((1 << (BR_LATCH + 1)) - 1); pc = 1; src = 1;
         m_lu_left = 0;
      end else if (m_lu_left > 0 || lu) begin
         en = NL'(all_ones - 1); fl = NL'(2);
         if (m_lu_left > 0) m_lu_left--;
         else m_lu_left = LU_CYC - 1;
      end else if (v.halt && v.ihit) begin
         en = NL'(all_ones); pc = 1;
         m_drain_left = STAGES - 2;
      end else if (!v.ihit) begin
         en = NL'(all_ones); fl = NL'(1);
      end else begin
         en = NL'(all_ones); pc = 1;
      end
      if (!pc && !hlt && m_stall < (1 << CNTW) - 1) m_stall++;
   endtask

   // ---------------- test ----------------
   initial begin
      idle_v   = mk_in(H, H, L, L, L, 0, 0, 0, L, L, L);
      lu_v     = mk_in(H, H, L, L, H, 5, 5, 0, L, L, L);
      dw_v     = mk_in(H, L, H, L, L, 0, 0, 0, L, L, L);
      halt_v   = mk_in(H, H, L, L, L, 0, 0, 0, L, L, H);
      noihit_v = mk_in(L, H, L, L, L, 0, 0, 0, L, L, L);
      br_lu_v  = mk_in(H, H, L, L, H, 5, 5, 0, L, H, L);
      br_v     = mk_in(H, H, L, L, L, 0, 0, 0, L, H, L);

      // Single cycle straight out of reset.
      add_vec(idle_v,                                 4'hF, 4'h0, H, L, "run");
      add_vec(noihit_v,                               4'hF, 4'h1, L, L, "no_ihit");
      add_vec(lu_v,                                   4'hE, 4'h2, L, L, "lu_rs");
      add_vec(mk_in(H, H, L, L, H, 0, 0, 0, H, L, L), 4'hF, 4'h0, H, L, "lu_r0");
      add_vec(mk_in(H, H, L, L, H, 5, 3, 5, L, L, L), 4'hF, 4'h0, H, L, "rt_unused");
      add_vec(mk_in(H, H, L, L, H, 5, 3, 5, H, L, L), 4'hE, 4'h2, L, L, "lu_rt");
      add_vec(mk_in(H, H, L, L, L, 5, 5, 0, L, L, L), 4'hF, 4'h0, H, L, "not_load");
      add_vec(br_lu_v,                                4'hF, 4'h7, H, H, "br_lu");
      add_vec(dw_v,                                   4'h0, 4'h0, L, L, "dwait_rd");
      add_vec(mk_in(H, H, L, H, L, 0, 0, 0, L, L, L), 4'hF, 4'h0, H, L, "wr_hit");
      add_vec(mk_in(H, L, L, H, L, 0, 0, 0, L, H, L), 4'h0, 4'h0, L, L, "dwait_br");
      add_vec(mk_in(H, L, H, L, H, 5, 5, 0, L, L, L), 4'h0, 4'h0, L, L, "dwait_lu");
      add_vec(halt_v,                                 4'hF, 4'h0, H, L, "halt_ihit");
      add_vec(mk_in(L, H, L, L, L, 0, 0, 0, L, L, H), 4'hF, 4'h1, L, L, "halt_noihit");
      add_vec(mk_in(L, H, L, L, L, 0, 0, 0, L, H, L), 4'hF, 4'h7, H, H, "br_noihit");

      foreach (tbl[i]) begin
         do_reset();
         step(tbl[i].in, tbl[i].en, tbl[i].fl, tbl[i].pc, tbl[i].src, L, 0, tbl[i].name);
      end

      // Load-use with LU_CYC=2: exactly two bubble cycles, then RUN.
      do_reset();
      step(lu_v,   4'hE, 4'h2, L, L, L, 0, "lu2_c1");
      step(lu_v,   4'hE, 4'h2, L, L, L, 1, "lu2_c2");
      step(idle_v, 4'hF, 4'h0, H, L, L, 2, "lu2_run");

      // Data wait inside LU_STALL freezes the bubble count.
      do_reset();
      step(lu_v,   4'hE, 4'h2, L, L, L, 0, "luw_c1");
      for (int k = 0; k < 3; k++) step(dw_v, 4'h0, 4'h0, L, L, L, 1 + k, "luw_dwait");
      step(idle_v, 4'hE, 4'h2, L, L, L, 4, "luw_c2");
      step(idle_v, 4'hF, 4'h0, H, L, L, 5, "luw_run");

      // Branch aborts LU_STALL.
      do_reset();
      step(lu_v,    4'hE, 4'h2, L, L, L, 0, "lubr_c1");
      step(br_lu_v, 4'hF, 4'h7, H, H, L, 1, "lubr_br");
      step(idle_v,  4'hF, 4'h0, H, L, L, 1, "lubr_run");

      // Halt drain with one data wait, then sticky HALTED.
      do_reset();
      step(halt_v, 4'hF, 4'h0, H, L, L, 0, "halt");
      step(idle_v, 4'hF, 4'h1, L, L, L, 0, "drain1");
      step(dw_v,   4'h0, 4'h0, L, L, L, 1, "drain_dwait");
      step(br_v,   4'hF, 4'h1, L, L, L, 2, "drain2_br");
      step(idle_v, 4'hF, 4'h1, L, L, L, 3, "drain3");
      step(idle_v, 4'h0, 4'h0, L, L, H, 4, "halted");
      step(br_v,   4'h0, 4'h0, L, L, H, 4, "halted_br");
      step(lu_v,   4'h0, 4'h0, L, L, H, 4, "halted_lu");

      // Reset in the middle of DRAIN.
      do_reset();
      step(halt_v, 4'hF, 4'h0, H, L, L, 0, "halt_b");
      step(idle_v, 4'hF, 4'h1, L, L, L, 0, "drain1_b");
      do_reset();
      step(idle_v, 4'hF, 4'h0, H, L, L, 0, "after_rst");

      // stall_cycles saturates at 15.
      do_reset();
      for (int k = 0; k < 18; k++) step(noihit_v, 4'hF, 4'h1, L, L, L, (k < 15) ? k : 15, "sat");
      step(idle_v, 4'hF, 4'h0, H, L, L, 15, "sat_hold");

      // Random traffic against the model.
      do_reset();
      model_reset();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 99) < 2) begin
            do_reset();
            model_reset();
         end else begin
            in_t           v;
            logic [NL-1:0] e_en, e_fl;
            logic          e_pc, e_src, e_h;
            int            e_st;
            v.ihit    = ($urandom_range(0, 9) < 8);
            v.dhit    = ($urandom_range(0, 9) < 7);
            v.ren     = ($urandom_range(0, 9) < 3);
            v.wen     = ($urandom_range(0, 9) < 1);
            v.dren    = ($urandom_range(0, 9) < 4);
            v.rt_ex   = REGW'($urandom_range(0, 3));
            v.rs_id   = REGW'($urandom_range(0, 3));
            v.rt_id   = REGW'($urandom_range(0, 3));
            v.rt_used = ($urandom_range(0, 1) == 1);
            v.br      = ($urandom_range(0, 9) < 1);
            v.halt    = ($urandom_range(0, 49) == 0);
            model_eval(v, e_en, e_fl, e_pc, e_src, e_h, e_st);
            step(v, e_en, e_fl, e_pc, e_src, e_h, e_st, "random");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
